// File: rtl/divisor_algoritmico.sv
// Multicycle restoring integer divider with a start/done handshake.
// One quotient bit per clock; a division takes tamanyo+2 clocks from IDLE back to IDLE.
// Optional feature: define DIVISOR_SIGNED_EN for two's complement signed operands and results.
// With the macro undefined the unit divides unsigned operands.
module divisor_algoritmico #(
   parameter int unsigned tamanyo = 32
) (
   input  logic               CLK,
   input  logic               RSTa,
   input  logic               Start,
   input  logic [tamanyo-1:0] Num,
   input  logic [tamanyo-1:0] Den,
   output logic [tamanyo-1:0] Coc,
   output logic [tamanyo-1:0] Res,
   output logic               Done
);

   localparam int unsigned W  = tamanyo;
   localparam int unsigned CW = (tamanyo > 2) ? $clog2(tamanyo) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [W:0]      rem_q,   rem_d;
   logic [W-1:0]    quo_q,   quo_d;
   logic [W-1:0]    dvs_q,   dvs_d;
   logic [W-1:0]    coc_q,   coc_d;
   logic [W-1:0]    res_q,   res_d;
   logic            done_q,  done_d;
`ifdef DIVISOR_SIGNED_EN
   logic            quo_neg_q, quo_neg_d;
   logic            rem_neg_q, rem_neg_d;
   logic            dz_q,      dz_d;
`endif

   // Trial subtraction: shifted partial remainder with the next dividend MSB minus the divisor.
   // The top bit of the result is set when the difference is negative.
   logic [W+1:0]    trial;
   assign trial = {rem_q, quo_q[W-1]} - {2'b00, dvs_q};

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      coc_d   = coc_q;
      res_d   = res_q;
      done_d  = 1'b0;
`ifdef DIVISOR_SIGNED_EN
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      dz_d      = dz_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (Start) begin
`ifdef DIVISOR_SIGNED_EN
               quo_d     = Num[W-1] ? (~Num + W'(1)) : Num;
               dvs_d     = Den[W-1] ? (~Den + W'(1)) : Den;
               quo_neg_d = Num[W-1] ^ Den[W-1];
               rem_neg_d = Num[W-1];
               dz_d      = (Den == '0);
`else
               quo_d     = Num;
               dvs_d     = Den;
`endif
               rem_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (!trial[W+1]) begin
               rem_d = trial[W:0];
               quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
               rem_d = {rem_q[W-1:0], quo_q[W-1]};
               quo_d = {quo_q[W-2:0], 1'b0};
            end
            if (cnt_q == CW'(W-1)) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FIX: begin
`ifdef DIVISOR_SIGNED_EN
            // Divide by zero reports all ones regardless of the dividend sign.
            if (dz_q) begin
               coc_d = '1;
            end else begin
               coc_d = quo_neg_q ? (~quo_q + W'(1)) : quo_q;
            end
            res_d = rem_neg_q ? (~rem_q[W-1:0] + W'(1)) : rem_q[W-1:0];
`else
            coc_d = quo_q;
            res_d = rem_q[W-1:0];
`endif
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         coc_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         coc_q   <= coc_d;
         res_q   <= res_d;
         done_q  <= done_d;
`ifdef DIVISOR_SIGNED_EN
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         dz_q      <= dz_d;
`endif
      end
   end

   assign Coc  = coc_q;
   assign Res  = res_q;
   assign Done = done_q;

endmodule

// File: tb/tb_divisor_algoritmico.sv
// Scoreboard bench for divisor_algoritmico (tamanyo = 32).
// Honours DIVISOR_SIGNED_EN the same way as the design.
module tb_divisor_algoritmico;

   localparam int unsigned W   = 32;
   localparam int unsigned LAT = W + 1;

   logic         CLK;
   logic         RSTa;
   logic         Start;
   logic [W-1:0] Num;
   logic [W-1:0] Den;
   logic [W-1:0] Coc;
   logic [W-1:0] Res;
   logic         Done;

   divisor_algoritmico #(.tamanyo(W)) dut (
      .CLK   (CLK),
      .RSTa  (RSTa),
      .Start (Start),
      .Num   (Num),
      .Den   (Den),
      .Coc   (Coc),
      .Res   (Res),
      .Done  (Done)
   );

   typedef struct {
      logic [W-1:0] coc;
      logic [W-1:0] res;
      int unsigned  cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc;
   int unsigned n_checks;
   int unsigned n_pass;
   int unsigned timeouts;
   bit          end_req;
   bit          mon_done;
   logic [W-1:0] last_coc;
   logic [W-1:0] last_res;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Reference: truncating division from plain arithmetic, with the documented corner cases.
   function automatic void ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      if (d == '0) begin
         q = '1;
         r = n;
      end else begin
`ifdef DIVISOR_SIGNED_EN
         longint sn;
         longint sd;
         sn = longint'($signed(n));
         sd = longint'($signed(d));
         q  = W'(sn / sd);
         r  = W'(sn % sd);
`else
         q = n / d;
         r = n % d;
`endif
      end
   endfunction

   // Comparison helper, used only by the monitor process.
   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
   endtask

   // Monitor: reset values, results on Done, and output stability between results.
   always @(negedge CLK) begin
      exp_t e;
      if (!RSTa) begin
         chk("reset_coc", Coc, '0);
         chk("reset_res", Res, '0);
         chk("reset_done", W'(Done), '0);
         last_coc = '0;
         last_res = '0;
      end else if (Done) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got Done=1 required no result pending (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("coc", Coc, e.coc);
            chk("res", Res, e.res);
            chk("done_cycle", W'(cyc), W'(e.cyc));
         end
         last_coc = Coc;
         last_res = Res;
      end else begin
         chk("hold_coc", Coc, last_coc);
         chk("hold_res", Res, last_res);
      end
      if (end_req && !mon_done) begin
         chk("timeouts", W'(timeouts), '0);
         chk("leftover", W'(sb.size()), '0);
         mon_done = 1'b1;
      end
   end

   // Present operands for one edge and queue the given expected result.
   task automatic issue_exp(input logic [W-1:0] n, input logic [W-1:0] d,
                            input logic [W-1:0] q, input logic [W-1:0] r);
      exp_t e;
      Num   = n;
      Den   = d;
      Start = 1'b1;
      @(posedge CLK);
      #1;
      e.coc = q;
      e.res = r;
      e.cyc = cyc + LAT;
      sb.push_back(e);
      Start = 1'b0;
   endtask

   task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d);
      logic [W-1:0] q;
      logic [W-1:0] r;
      ref_div(n, d, q, r);
      issue_exp(n, d, q, r);
   endtask

   // Wait until every queued result has been seen, with a cycle budget.
   task automatic wait_idle();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 60) begin
         @(negedge CLK);
         k++;
      end
      if (sb.size() != 0) begin
         timeouts++;
         sb.delete();
      end
   endtask

   function automatic logic [W-1:0] rand_den(input int mode);
      case (mode)
         0: return $urandom;
         1: return W'($urandom_range(1, 300));
         2: return '0;
         3: return '1;
         4: return 32'd1;
         default: return W'(0) - W'($urandom_range(1, 300));
      endcase
   endfunction

   initial begin
      int unsigned acc;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic [W-1:0] n;
      n_checks = 0;
      n_pass   = 0;
      timeouts = 0;
      end_req  = 1'b0;
      mon_done = 1'b0;
      last_coc = '0;
      last_res = '0;
      RSTa  = 1'b0;
      Start = 1'b0;
      Num   = '0;
      Den   = '0;
      repeat (3) @(negedge CLK);
      #1 RSTa = 1'b1;
      @(negedge CLK);

      // Directed cases with hand-derived results.
      issue_exp(32'd1000, 32'd7, 32'd142, 32'd6);                wait_idle();
      issue_exp(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);             wait_idle();
      issue_exp(32'd3, 32'd10, 32'd0, 32'd3);                    wait_idle();
`ifdef DIVISOR_SIGNED_EN
      issue_exp(-32'sd7, 32'd2, -32'sd3, -32'sd1);                wait_idle();
      issue_exp(32'd7, -32'sd2, -32'sd3, 32'd1);                  wait_idle();
      issue_exp(-32'sd7, -32'sd2, 32'd3, -32'sd1);                wait_idle();
      issue_exp(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0); wait_idle();
`else
      issue_exp(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);     wait_idle();
      issue_exp(32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);    wait_idle();
      issue_exp(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000); wait_idle();
`endif

      // Reset in the middle of a division discards it.
      issue_exp(32'd1000, 32'd7, 32'd142, 32'd6);
      repeat (9) @(posedge CLK);
      #2 RSTa = 1'b0;
      sb.delete();
      repeat (2) @(negedge CLK);
      #1 RSTa = 1'b1;
      @(negedge CLK);
      issue_exp(32'd1000, 32'd7, 32'd142, 32'd6);                wait_idle();

      // Start pulses with other operands during CALC are ignored.
      issue_exp(32'd100, 32'd3, 32'd33, 32'd1);
      repeat (2) @(negedge CLK);
      Num = $urandom; Den = 32'd5; Start = 1'b1;
      @(negedge CLK); Start = 1'b0;
      repeat (12) @(negedge CLK);
      Num = $urandom; Den = 32'd9; Start = 1'b1;
      @(negedge CLK); Start = 1'b0;
      repeat (10) @(negedge CLK);
      Num = $urandom; Den = 32'd2; Start = 1'b1;
      @(negedge CLK); Start = 1'b0;
      wait_idle();

      // Start held high for 100 edges: a new division every W+2 clocks.
      @(negedge CLK);
      Num = 32'd12345; Den = 32'd67; Start = 1'b1;
      ref_div(32'd12345, 32'd67, q, r);
      acc = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge CLK);
         #1;
         if (i == 0 || cyc - acc == W + 2) begin
            exp_t e;
            e.coc = q;
            e.res = r;
            e.cyc = cyc + LAT;
            sb.push_back(e);
            acc = cyc;
         end
      end
      Start = 1'b0;
      wait_idle();

      // Randomized regression against the reference model.
      for (int i = 0; i < 600; i++) begin
         n = $urandom;
         if ($urandom_range(0, 7) == 0) n = 32'h8000_0000;
         if ($urandom_range(0, 7) == 0) n = W'($urandom_range(0, 20));
         issue(n, rand_den(int'($urandom_range(0, 5))));
         wait_idle();
      end

      end_req = 1'b1;
      for (int k = 0; k < 5 && !mon_done; k++) @(negedge CLK);
      #1;
      if (!mon_done) begin
         $display("FAIL monitor_end: got no final check required completion");
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
